inst_encoder: RTL and testbench

Instruction encoder and program loader for the LEGv8-subset single-cycle CPU. It accepts one symbolic instruction per handshake: an operation select plus register and immediate fields. It packs the fields into the 32-bit machine word that the CPU's control decoder expects, range-checks the immediates, and writes the words sequentially into instruction memory. Testbenches and the boot path use it to build programs without hand-assembled hex.

---
 rtl/inst_encoder.sv | 108 ++++++++++
 tb/tb_inst_encoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: packs symbolic LEGv8-subset instructions into 32-bit machine words
// and writes them sequentially into instruction memory.
module inst_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [3:0]        i_op_sel,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_rn,
    input  logic [4:0]        i_rm,
    input  logic [5:0]        i_shamt,
    input  logic [25:0]       i_imm,
    input  logic              i_in_last,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_ready,
    output logic              o_err,
    output logic              o_done,
    output logic              o_full,
    output logic [6:0]        o_count
);
    typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_FULL} state_t;
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, w_word;
    logic [6:0]        r_count;
    logic              r_err, r_last, w_illegal, w_hs, w_wr_done, w_restart;
    always_comb begin
        w_word    = '0;
        w_illegal = 1'b0;
        case (i_op_sel)
            4'd0: begin
                w_word    = {10'b1001000100, i_imm[11:0], i_rn, i_rd};
                w_illegal = |i_imm[25:12];
            end
            4'd1: w_word = {11'b10101011000, i_rm, 6'd0, i_rn, i_rd};
            4'd2: w_word = {11'b11101011000, i_rm, 6'd0, i_rn, i_rd};
            4'd3: w_word = {11'b11010011011, 5'd0, i_shamt, i_rn, i_rd};
            4'd4: w_word = {11'b11010011010, 5'd0, i_shamt, i_rn, i_rd};
            4'd5: w_word = {11'b10011011000, i_rm, 6'b011111, i_rn, i_rd};
            4'd6, 4'd7: begin
                w_word    = {(i_op_sel[0] ? 11'b11111000000 : 11'b11111000010), i_imm[8:0], 2'b00, i_rn, i_rd};
                w_illegal = i_imm[25:8] != {18{i_imm[8]}};
            end
            4'd8: w_word = {6'b000101, i_imm};
            4'd9: begin
                w_word    = {8'b01010100, i_imm[18:0], 5'b01011};
                w_illegal = i_imm[25:18] != {8{i_imm[18]}};
            end
            4'd10: begin
                w_word    = {8'b10110100, i_imm[18:0], i_rd};
                w_illegal = i_imm[25:18] != {8{i_imm[18]}};
            end
            default: w_illegal = 1'b1;
        endcase
    end
    // start is ignored only while a write is outstanding
    assign w_restart = i_start && r_state != S_WRITE;
    assign w_hs      = r_state == S_ACCEPT && i_in_valid && !i_start;
    assign w_wr_done = r_state == S_WRITE && i_mem_ready;
    always_comb begin
        w_next = r_state;
        if (w_restart)
            w_next = S_ACCEPT;
        else if (w_hs && !w_illegal)
            w_next = S_WRITE;
        else if (w_wr_done)
            w_next = r_last ? S_DONE : (r_count + 7'd1 == 7'(MAX_WORDS)) ? S_FULL : S_ACCEPT;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= ADDR_W'(BASE_ADDR);
            r_wdata <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_hs && w_illegal;
            if (w_restart) begin
                r_addr  <= ADDR_W'(BASE_ADDR);
                r_count <= '0;
            end else if (w_hs && !w_illegal) begin
                r_wdata <= w_word;
                r_last  <= i_in_last;
            end else if (w_wr_done) begin
                r_count <= r_count + 7'd1;
                r_addr  <= r_addr + ADDR_W'(4);
            end
        end
    end
    assign o_in_ready  = r_state == S_ACCEPT;
    assign o_mem_we    = r_state == S_WRITE;
    assign o_done      = r_state == S_DONE;
    assign o_full      = r_state == S_FULL;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_count     = r_count;
    assign o_err       = r_err;
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: randomized and directed checks of inst_encoder against an
// arithmetic reference model of the instruction encodings.
module tb_inst_encoder;
    logic        clk = 0, rst_n = 0, start = 0, s_start = 0, in_valid = 0, in_last = 0, mem_ready = 1;
    logic [3:0]  op_sel = 0;
    logic [4:0]  rd = 0, rn = 0, rm = 0;
    logic [5:0]  shamt = 0;
    logic [25:0] imm = 0;
    logic        in_ready, mem_we, err, done, full;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  count;
    logic        sm_in_ready, sm_mem_we, sm_err, sm_done, sm_full;
    logic [7:0]  sm_mem_addr;
    logic [31:0] sm_mem_wdata;
    logic [6:0]  sm_count;
    int          n_pass = 0, n_total = 0, exp_count = 0, exp_addr = 0;
    logic [31:0] got;

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(8), .BASE_ADDR(0), .MAX_WORDS(64)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op_sel(op_sel), .i_rd(rd), .i_rn(rn), .i_rm(rm), .i_shamt(shamt), .i_imm(imm),
        .i_in_last(in_last), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .o_err(err), .o_done(done), .o_full(full), .o_count(count));

    inst_encoder #(.ADDR_W(8), .BASE_ADDR(0), .MAX_WORDS(2)) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_in_valid(in_valid), .o_in_ready(sm_in_ready),
        .i_op_sel(op_sel), .i_rd(rd), .i_rn(rn), .i_rm(rm), .i_shamt(shamt), .i_imm(imm),
        .i_in_last(in_last), .o_mem_we(sm_mem_we), .o_mem_addr(sm_mem_addr), .o_mem_wdata(sm_mem_wdata),
        .i_mem_ready(mem_ready), .o_err(sm_err), .o_done(sm_done), .o_full(sm_full), .o_count(sm_count));

    // reference encoder: field values placed by arithmetic, ranges checked on signed integers
    function automatic logic [31:0] model(input logic [3:0] op, input logic [4:0] d, n, m,
                                          input logic [5:0] sh, input logic [25:0] im, output bit legal);
        longint si = longint'($signed(im));
        longint ui = longint'(im);
        longint w = 0;
        longint regs = longint'(n) * 32 + longint'(d);
        legal = 1;
        case (op)
            0: begin legal = ui <= 4095; w = 'h91000000 + (ui % 4096) * 1024 + regs; end
            1: w = 'h558 * (1 << 21) + longint'(m) * 65536 + regs;
            2: w = 'h758 * (1 << 21) + longint'(m) * 65536 + regs;
            3: w = 'h69B * (1 << 21) + longint'(sh) * 1024 + regs;
            4: w = 'h69A * (1 << 21) + longint'(sh) * 1024 + regs;
            5: w = 'h4D8 * (1 << 21) + longint'(m) * 65536 + 31 * 1024 + regs;
            6, 7: begin
                legal = si >= -256 && si <= 255;
                w = (op == 6 ? 'h7C2 : 'h7C0) * (1 << 21) + ((si + 512) % 512) * 4096 + regs;
            end
            8: w = 5 * (1 << 26) + ui;
            9, 10: begin
                legal = si >= -(1 << 18) && si < (1 << 18);
                w = (op == 9 ? 'h54 : 'hB4) * (1 << 24) + ((si + (1 << 19)) % (1 << 19)) * 32
                    + (op == 9 ? 11 : longint'(d));
            end
            default: legal = 0;
        endcase
        return 32'(w);
    endfunction

    task automatic do_start();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        exp_count = 0;
        exp_addr = 0;
        n_total++;
        if (in_ready !== 1'b1 || count !== 7'd0 || done !== 1'b0 || full !== 1'b0)
            $display("FAIL start: in_ready=%b count=%0d done=%b full=%b, want 1/0/0/0", in_ready, count, done, full);
        else n_pass++;
    endtask

    task automatic offer(input logic [3:0] op, input logic [4:0] d, n, m, input logic [5:0] sh,
                         input logic [25:0] im, input logic last, input int stall, output logic [31:0] got_w);
        bit lg;
        logic [31:0] exp_w;
        int waited = 0;
        exp_w = model(op, d, n, m, sh, im, lg);
        got_w = 'x;
        op_sel = op; rd = d; rn = n; rm = m; shamt = sh; imm = im; in_last = last; in_valid = 1;
        while (!in_ready && waited < 10) begin @(posedge clk); #1; waited++; end
        n_total++;
        if (in_ready !== 1'b1) begin
            $display("FAIL ready_timeout: in_ready=%b, want 1", in_ready);
            in_valid = 0;
            return;
        end
        n_pass++;
        @(posedge clk); #1;
        in_valid = 0;
        if (!lg) begin
            n_total++;
            if (err !== 1'b1 || mem_we !== 1'b0 || count !== 7'(exp_count) || in_ready !== 1'b1)
                $display("FAIL reject op=%0d imm=%h: err=%b we=%b count=%0d rdy=%b, want 1/0/%0d/1",
                         op, im, err, mem_we, count, in_ready, exp_count);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (err !== 1'b0) $display("FAIL err_pulse: err=%b, want 0", err);
            else n_pass++;
            return;
        end
        got_w = mem_wdata;
        n_total++;
        if (mem_we !== 1'b1 || in_ready !== 1'b0 || mem_addr !== 8'(exp_addr) || mem_wdata !== exp_w)
            $display("FAIL write op=%0d: we=%b rdy=%b addr=%h data=%h, want 1/0/%h/%h",
                     op, mem_we, in_ready, mem_addr, mem_wdata, 8'(exp_addr), exp_w);
        else n_pass++;
        mem_ready = stall == 0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (i == stall - 1) mem_ready = 1;
            n_total++;
            if (mem_we !== 1'b1 || in_ready !== 1'b0 || mem_addr !== 8'(exp_addr) || mem_wdata !== exp_w || count !== 7'(exp_count))
                $display("FAIL stall_hold %0d: we=%b rdy=%b addr=%h data=%h count=%0d, want 1/0/%h/%h/%0d",
                         i, mem_we, in_ready, mem_addr, mem_wdata, count, 8'(exp_addr), exp_w, exp_count);
            else n_pass++;
        end
        @(posedge clk); #1;
        exp_count++;
        exp_addr += 4;
        n_total++;
        if (mem_we !== 1'b0 || count !== 7'(exp_count) || mem_addr !== 8'(exp_addr) || in_ready !== !last || done !== last)
            $display("FAIL commit: we=%b count=%0d addr=%h rdy=%b done=%b, want 0/%0d/%h/%b/%b",
                     mem_we, count, mem_addr, in_ready, done, exp_count, 8'(exp_addr), !last, last);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        n_total++;
        if (in_ready !== 0 || mem_we !== 0 || mem_addr !== 8'h00 || mem_wdata !== 32'h0 || err !== 0
            || done !== 0 || full !== 0 || count !== 7'd0)
            $display("FAIL reset_values: rdy=%b we=%b addr=%h data=%h err=%b done=%b full=%b count=%0d, want all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, err, done, full, count);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL idle_ready: in_ready=%b, want 0", in_ready);
        else n_pass++;
    endtask

    task automatic test_addi();
        do_start();
        offer(4'd0, 5'd1, 5'd31, 5'd0, 6'd0, 26'd5, 1'b0, 0, got);
        n_total++;
        if (got !== 32'h910017E1) $display("FAIL addi_word: got %h, want 910017E1", got);
        else n_pass++;
    endtask

    task automatic test_sequence();
        logic [31:0] want [4] = '{32'hAB020023, 32'hF85F8064, 32'hB4000064, 32'h17FFFFFF};
        logic [31:0] w [4];
        do_start();
        offer(4'd1, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0, 1'b0, 0, w[0]);
        offer(4'd6, 5'd4, 5'd3, 5'd0, 6'd0, -26'sd8, 1'b0, 0, w[1]);
        offer(4'd10, 5'd4, 5'd0, 5'd0, 6'd0, 26'd3, 1'b0, 0, w[2]);
        offer(4'd8, 5'd0, 5'd0, 5'd0, 6'd0, -26'sd1, 1'b1, 0, w[3]);
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (w[i] !== want[i]) $display("FAIL seq_word%0d: got %h, want %h", i, w[i], want[i]);
            else n_pass++;
        end
        n_total++;
        if (done !== 1'b1 || count !== 7'd4 || in_ready !== 1'b0)
            $display("FAIL seq_done: done=%b count=%0d rdy=%b, want 1/4/0", done, count, in_ready);
        else n_pass++;
    endtask

    task automatic test_illegal();
        do_start();
        offer(4'd0, 5'd1, 5'd2, 5'd0, 6'd0, 26'd7, 1'b0, 0, got);
        offer(4'd6, 5'd1, 5'd2, 5'd0, 6'd0, 26'd300, 1'b0, 0, got);
        offer(4'd13, 5'd1, 5'd2, 5'd3, 6'd0, 26'd0, 1'b0, 0, got);
        offer(4'd0, 5'd1, 5'd2, 5'd0, 6'd0, 26'd4096, 1'b0, 0, got);
        n_total++;
        if (count !== 7'd1 || in_ready !== 1'b1 || mem_we !== 1'b0)
            $display("FAIL illegal_state: count=%0d rdy=%b we=%b, want 1/1/0", count, in_ready, mem_we);
        else n_pass++;
    endtask

    task automatic test_stall();
        do_start();
        offer(4'd3, 5'd7, 5'd8, 5'd9, 6'd13, 26'd0, 1'b0, 5, got);
        offer(4'd5, 5'd2, 5'd4, 5'd6, 6'd0, 26'd0, 1'b0, 1, got);
    endtask

    task automatic test_random();
        do_start();
        for (int k = 0; k < 40; k++) begin
            logic [3:0] op;
            logic [25:0] im;
            op = (k == 39) ? 4'd8 : 4'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) im = 26'($urandom);
            else begin
                im = 26'($urandom_range(0, 4600));
                if ($urandom_range(0, 1) == 1) im = -im;
            end
            offer(op, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), im, k == 39,
                  int'($urandom_range(0, 2)), got);
        end
    endtask

    task automatic test_full();
        rst_n = 0;
        #2 rst_n = 1;
        @(posedge clk); #1;
        s_start = 1;
        @(posedge clk); #1;
        s_start = 0;
        for (int i = 0; i < 2; i++) begin
            op_sel = 0; rd = 5'(i); rn = 0; imm = 26'(i + 1); in_last = 0; in_valid = 1;
            @(posedge clk); #1;
            in_valid = 0;
            n_total++;
            if (sm_mem_we !== 1'b1 || sm_mem_addr !== 8'(4 * i))
                $display("FAIL full_write%0d: we=%b addr=%h, want 1/%h", i, sm_mem_we, sm_mem_addr, 8'(4 * i));
            else n_pass++;
            @(posedge clk); #1;
        end
        n_total++;
        if (sm_full !== 1'b1 || sm_in_ready !== 1'b0 || sm_count !== 7'd2 || sm_done !== 1'b0)
            $display("FAIL full_state: full=%b rdy=%b count=%0d done=%b, want 1/0/2/0", sm_full, sm_in_ready, sm_count, sm_done);
        else n_pass++;
        op_sel = 0; rd = 5'd9; rn = 5'd3; imm = 26'd77; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_total++;
            if (sm_mem_we !== 1'b0 || sm_count !== 7'd2)
                $display("FAIL full_block%0d: we=%b count=%0d, want 0/2", i, sm_mem_we, sm_count);
            else n_pass++;
        end
        s_start = 1;
        @(posedge clk); #1;
        s_start = 0;
        n_total++;
        if (sm_full !== 1'b0 || sm_in_ready !== 1'b1 || sm_count !== 7'd0)
            $display("FAIL full_restart: full=%b rdy=%b count=%0d, want 0/1/0", sm_full, sm_in_ready, sm_count);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 0;
        n_total++;
        if (sm_mem_we !== 1'b1 || sm_mem_addr !== 8'h00 || sm_mem_wdata !== 32'h91013469)
            $display("FAIL full_third: we=%b addr=%h data=%h, want 1/00/91013469", sm_mem_we, sm_mem_addr, sm_mem_wdata);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (sm_count !== 7'd1 || sm_mem_addr !== 8'h04)
            $display("FAIL full_third_commit: count=%0d addr=%h, want 1/04", sm_count, sm_mem_addr);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_start();
        op_sel = 4'd2; rd = 5'd1; rn = 5'd2; rm = 5'd3; in_last = 0; in_valid = 1; mem_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        n_total++;
        if (mem_we !== 1'b1) $display("FAIL arst_pre: we=%b, want 1", mem_we);
        else n_pass++;
        #2 rst_n = 0;
        #1;
        n_total++;
        if (mem_we !== 0 || in_ready !== 0 || mem_addr !== 8'h00 || mem_wdata !== 32'h0 || err !== 0
            || done !== 0 || full !== 0 || count !== 7'd0)
            $display("FAIL arst_values: we=%b rdy=%b addr=%h data=%h err=%b done=%b full=%b count=%0d, want all 0",
                     mem_we, in_ready, mem_addr, mem_wdata, err, done, full, count);
        else n_pass++;
        mem_ready = 1;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        n_total++;
        if (in_ready !== 1'b0 || mem_we !== 1'b0 || count !== 7'd0)
            $display("FAIL arst_idle: rdy=%b we=%b count=%0d, want 0/0/0", in_ready, mem_we, count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sequence();
        test_illegal();
        test_stall();
        test_random();
        test_full();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
